// File: rtl/keycode_frame_decoder_pkg.sv
// Shared key codes and chop auto-repeat state encoding for the keycode frame decoder.
package keycode_pkg;

    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_J     = 8'h0D;
    localparam logic [7:0] KEY_K     = 8'h0E;
    localparam logic [7:0] KEY_ENTER = 8'h28;

    // One presence detector per entry; IDX_* select the matching hit bit.
    localparam int NUM_KEYS  = 7;
    localparam int IDX_W     = 0;
    localparam int IDX_A     = 1;
    localparam int IDX_S     = 2;
    localparam int IDX_D     = 3;
    localparam int IDX_J     = 4;
    localparam int IDX_K     = 5;
    localparam int IDX_ENTER = 6;
    localparam logic [NUM_KEYS-1:0][7:0] KEY_LIST =
        {KEY_ENTER, KEY_K, KEY_J, KEY_D, KEY_S, KEY_A, KEY_W};

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} chop_state_t;

endpackage

// File: rtl/keycode_frame_decoder_key_present.sv
// Flags whether any of the four HID keycode bytes equals the given code; 0x00 never matches.
module key_present (
    input  logic [31:0] word_i,
    input  logic [7:0]  code_i,
    output logic        hit_o
);

    always_comb begin
        hit_o = (code_i != 8'h00) &&
                ((word_i[7:0]   == code_i) || (word_i[15:8]  == code_i) ||
                 (word_i[23:16] == code_i) || (word_i[31:24] == code_i));
    end

endmodule

// File: rtl/keycode_frame_decoder.sv
// Turns the asynchronous GPIO keycode word into per-frame game controls sampled on vsync falls.
module keycode_frame_decoder
    import keycode_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int REPEAT_DELAY  = 15,
    parameter int REPEAT_RATE   = 6
) (
    input  logic        Clk,
    input  logic        reset_rtl_0,
    input  logic [31:0] keycode,
    input  logic        vsync,
    output logic        frame_tick,
    output logic [3:0]  dir,
    output logic        pickup_pulse,
    output logic        chop_pulse,
    output logic        start_pulse,
    output logic [31:0] keycode_sync
);

    localparam logic [3:0] STAB_MAX = 4'(STABLE_CYCLES - 1);

    logic [31:0] kc_meta_q, kc_sync_q, kc_prev_q, keycode_sync_q, keycode_sync_d;
    logic [3:0]  stab_cnt_q, stab_cnt_d;
    logic        vs_meta_q, vs_sync_q, vs_hist_q, vs_fall;
    logic        frame_tick_q, pickup_q, chop_q, start_q;
    logic [3:0]  dir_q, dir_d;
    logic        j_prev_q, ent_prev_q;
    chop_state_t chop_state_q, chop_state_d;
    logic [4:0]  chop_cnt_q, chop_cnt_d, chop_inc;
    logic        chop_fire;
    logic [NUM_KEYS-1:0] hit;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_kp
        key_present u_kp (
            .word_i (keycode_sync_q),
            .code_i (KEY_LIST[g]),
            .hit_o  (hit[g])
        );
    end

    // The counter saturates so a long-held word keeps reloading the same value.
    always_comb begin
        stab_cnt_d     = '0;
        keycode_sync_d = keycode_sync_q;
        if (kc_sync_q == kc_prev_q)
            stab_cnt_d = (stab_cnt_q == STAB_MAX) ? stab_cnt_q : stab_cnt_q + 4'd1;
        if (stab_cnt_d == STAB_MAX)
            keycode_sync_d = kc_sync_q;
    end

    assign vs_fall = vs_hist_q & ~vs_sync_q;

    always_comb begin
        dir_d = {hit[IDX_W] & ~hit[IDX_S], hit[IDX_S] & ~hit[IDX_W],
                 hit[IDX_A] & ~hit[IDX_D], hit[IDX_D] & ~hit[IDX_A]};
    end

    always_comb begin
        chop_state_d = chop_state_q;
        chop_cnt_d   = chop_cnt_q;
        chop_fire    = 1'b0;
        chop_inc     = chop_cnt_q + 5'd1;
        if (vs_fall) begin
            if (!hit[IDX_K]) begin
                chop_state_d = IDLE;
                chop_cnt_d   = '0;
            end else begin
                case (chop_state_q)
                    IDLE: begin
                        chop_fire    = 1'b1;
                        chop_cnt_d   = '0;
                        chop_state_d = DELAY;
                    end
                    DELAY: begin
                        chop_cnt_d = chop_inc;
                        if (chop_inc == 5'(REPEAT_DELAY)) begin
                            chop_fire    = 1'b1;
                            chop_cnt_d   = '0;
                            chop_state_d = REPEAT;
                        end
                    end
                    REPEAT: begin
                        chop_cnt_d = chop_inc;
                        if (chop_inc == 5'(REPEAT_RATE)) begin
                            chop_fire  = 1'b1;
                            chop_cnt_d = '0;
                        end
                    end
                    default: begin
                        chop_state_d = IDLE;
                        chop_cnt_d   = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge Clk or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            kc_meta_q      <= '0;
            kc_sync_q      <= '0;
            kc_prev_q      <= '0;
            stab_cnt_q     <= '0;
            keycode_sync_q <= '0;
            vs_meta_q      <= 1'b0;
            vs_sync_q      <= 1'b0;
            vs_hist_q      <= 1'b0;
            frame_tick_q   <= 1'b0;
            dir_q          <= '0;
            pickup_q       <= 1'b0;
            chop_q         <= 1'b0;
            start_q        <= 1'b0;
            j_prev_q       <= 1'b0;
            ent_prev_q     <= 1'b0;
            chop_state_q   <= IDLE;
            chop_cnt_q     <= '0;
        end else begin
            kc_meta_q      <= keycode;
            kc_sync_q      <= kc_meta_q;
            kc_prev_q      <= kc_sync_q;
            stab_cnt_q     <= stab_cnt_d;
            keycode_sync_q <= keycode_sync_d;
            vs_meta_q      <= vsync;
            vs_sync_q      <= vs_meta_q;
            vs_hist_q      <= vs_sync_q;
            frame_tick_q   <= vs_fall;
            pickup_q       <= vs_fall & hit[IDX_J] & ~j_prev_q;
            start_q        <= vs_fall & hit[IDX_ENTER] & ~ent_prev_q;
            chop_q         <= chop_fire;
            chop_state_q   <= chop_state_d;
            chop_cnt_q     <= chop_cnt_d;
            if (vs_fall) begin
                dir_q      <= dir_d;
                j_prev_q   <= hit[IDX_J];
                ent_prev_q <= hit[IDX_ENTER];
            end
        end
    end

    assign frame_tick   = frame_tick_q;
    assign dir          = dir_q;
    assign pickup_pulse = pickup_q;
    assign chop_pulse   = chop_q;
    assign start_pulse  = start_q;
    assign keycode_sync = keycode_sync_q;

endmodule

// File: tb/tb_keycode_frame_decoder.sv
// Directed bench for keycode_frame_decoder with a cycle-level reference model of the frame controls.
module tb_keycode_frame_decoder;

    localparam int S  = 4;
    localparam int RD = 15;
    localparam int RR = 6;
    localparam int HN = 24;

    logic        Clk, reset_rtl_0, vsync;
    logic [31:0] keycode;
    logic        frame_tick, pickup_pulse, chop_pulse, start_pulse;
    logic [3:0]  dir;
    logic [31:0] keycode_sync;

    keycode_frame_decoder #(.STABLE_CYCLES(S), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
        .Clk          (Clk),
        .reset_rtl_0  (reset_rtl_0),
        .keycode      (keycode),
        .vsync        (vsync),
        .frame_tick   (frame_tick),
        .dir          (dir),
        .pickup_pulse (pickup_pulse),
        .chop_pulse   (chop_pulse),
        .start_pulse  (start_pulse),
        .keycode_sync (keycode_sync)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vhalf = 500;
    int last_fall = 0;
    int pk_cnt = 0;
    bit chk_en = 0;
    bit t1_en = 0;

    // reference model state
    logic [31:0] kh [HN];
    logic        vh [HN];
    logic [31:0] exp_ksync;
    logic [3:0]  exp_dir;
    logic        exp_tick, exp_pk, exp_chop, exp_st, prev_j, prev_e;
    int          k_n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic bit has(input logic [31:0] w, input logic [7:0] k);
        bit r = 0;
        for (int b = 0; b < 4; b++) if (k != 8'h00 && w[8*b +: 8] == k) r = 1;
        return r;
    endfunction

    task automatic wait_ticks(input int n);
        int seen = 0;
        int budget = 0;
        while (seen < n && budget < 4000) begin
            @(negedge Clk);
            budget++;
            if (frame_tick) seen++;
        end
        if (seen < n) begin
            checks++;
            errors++;
            $display("FAIL wait_ticks timeout: saw %0d ticks, required %0d", seen, n);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < HN; i++) begin kh[i] = '0; vh[i] = 1'b0; end
        exp_ksync = '0; exp_dir = '0; exp_tick = 0; exp_pk = 0; exp_chop = 0; exp_st = 0;
        prev_j = 0; prev_e = 0; k_n = 0;
    endtask

    task automatic model_step();
        bit stable, w, a, s, d, j, k, e;
        for (int i = HN - 1; i > 0; i--) begin kh[i] = kh[i-1]; vh[i] = vh[i-1]; end
        kh[0] = keycode;
        vh[0] = vsync;
        // tick follows a synchronized 1->0 of vsync, i.e. raw samples two and three edges back
        exp_tick = !vh[2] && vh[3];
        exp_pk = 0; exp_chop = 0; exp_st = 0;
        if (exp_tick) begin
            w = has(exp_ksync, 8'h1A); a = has(exp_ksync, 8'h04);
            s = has(exp_ksync, 8'h16); d = has(exp_ksync, 8'h07);
            j = has(exp_ksync, 8'h0D); k = has(exp_ksync, 8'h0E);
            e = has(exp_ksync, 8'h28);
            exp_dir = {w && !s, s && !w, a && !d, d && !a};
            exp_pk = j && !prev_j; prev_j = j;
            exp_st = e && !prev_e; prev_e = e;
            k_n = k ? k_n + 1 : 0;
            exp_chop = k && (k_n == 1 || (k_n >= 1 + RD && (k_n - 1 - RD) % RR == 0));
        end
        // keycode_sync takes a word once S consecutive synchronized samples agree
        stable = 1;
        for (int i = 3; i < 2 + S; i++) if (kh[i] != kh[2]) stable = 0;
        if (stable) exp_ksync = kh[2];
    endtask

    initial begin
        Clk = 0;
        forever #5 Clk = ~Clk;
    end

    initial forever begin
        @(posedge Clk);
        cyc++;
    end

    initial begin
        model_reset();
        forever begin
            @(posedge Clk or negedge reset_rtl_0);
            if (!reset_rtl_0) model_reset();
            else model_step();
        end
    end

    initial begin
        vsync = 1'b1;
        forever begin
            repeat (vhalf) @(negedge Clk);
            vsync = ~vsync;
            if (!vsync) last_fall = cyc;
        end
    end

    initial forever begin
        @(negedge Clk);
        if (chk_en) begin
            chk("frame_tick", frame_tick, exp_tick);
            chk("dir", dir, exp_dir);
            chk("pickup_pulse", pickup_pulse, exp_pk);
            chk("chop_pulse", chop_pulse, exp_chop);
            chk("start_pulse", start_pulse, exp_st);
            chk("keycode_sync", keycode_sync, exp_ksync);
            if (pickup_pulse) pk_cnt++;
            if (t1_en && frame_tick) chk("tick_latency", cyc - last_fall, 3);
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tick"}, frame_tick, 0);
        chk({tag, "_dir"}, dir, 0);
        chk({tag, "_pulses"}, {pickup_pulse, chop_pulse, start_pulse}, 0);
        chk({tag, "_ksync"}, keycode_sync, 0);
    endtask

    initial begin
        logic [31:0] mask;
        reset_rtl_0 = 1'b0;
        keycode = '0;
        repeat (5) @(negedge Clk);
        chk_all_zero("reset");
        #2 reset_rtl_0 = 1'b1;
        @(negedge Clk);
        chk_en = 1;

        // 1: idle frames, tick three cycles after each raw vsync fall
        t1_en = 1;
        wait_ticks(2);
        t1_en = 0;
        chk("t1_dir", dir, 0);
        vhalf = 20;
        wait_ticks(2);

        // 2: up alone, then up+down cancel
        keycode = 32'h0000_001A;
        wait_ticks(1);
        chk("t2_up", dir, 4'b1000);
        keycode = 32'h0000_161A;
        wait_ticks(1);
        chk("t2_updown", dir, 4'b0000);

        // 3: two-cycle glitch is filtered
        keycode = '0;
        wait_ticks(1);
        keycode = 32'h0000_0004;
        repeat (2) @(negedge Clk);
        keycode = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            chk("t3_glitch_ksync", keycode_sync, 0);
        end
        wait_ticks(1);
        chk("t3_dir", dir, 0);

        // 4: J press, hold, release, press again
        pk_cnt = 0;
        keycode = 32'h0000_000D;
        wait_ticks(3);
        #1 chk("t4_one_pickup", pk_cnt, 1);
        keycode = '0;
        wait_ticks(1);
        keycode = 32'h0000_000D;
        wait_ticks(2);
        #1 chk("t4_two_pickups", pk_cnt, 2);
        keycode = '0;
        wait_ticks(1);

        // simultaneous Enter + J + right, then left+right cancel
        keycode = 32'h280D_0700;
        wait_ticks(1);
        chk("tm_pickup", pickup_pulse, 1);
        chk("tm_start", start_pulse, 1);
        chk("tm_dir", dir, 4'b0001);
        keycode = 32'h0000_0704;
        wait_ticks(1);
        chk("tm_lr_dir", dir, 4'b0000);
        chk("tm_nostart", start_pulse, 0);
        keycode = '0;
        wait_ticks(1);

        // 5: K held 30 frames
        mask = '0;
        keycode = 32'h0000_000E;
        for (int f = 1; f <= 30; f++) begin
            wait_ticks(1);
            if (chop_pulse) mask[f] = 1'b1;
        end
        chk("t5_chop_frames", mask, 32'h1041_0002);
        keycode = '0;
        wait_ticks(2);
        chk("t5_released", chop_pulse, 0);

        // 6: reset while repeating, K still held afterwards
        keycode = 32'h0000_000E;
        wait_ticks(20);
        repeat (10) @(negedge Clk);
        #2 reset_rtl_0 = 1'b0;
        #1 chk_all_zero("t6_reset");
        repeat (3) @(negedge Clk);
        #2 reset_rtl_0 = 1'b1;
        wait_ticks(1);
        chk("t6_first_chop", chop_pulse, 1);
        wait_ticks(2);

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
